lcd_request_arbiter: RTL and testbench



---
 rtl/lcd_request_arbiter_pkg.sv | 36 +++
 rtl/lcd_request_arbiter_rr_pick.sv | 28 ++
 rtl/lcd_request_arbiter.sv | 157 +++++++++++++++
 tb/tb_lcd_request_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_request_arbiter_pkg.sv
// Shared LCD interface definitions: payload widths, opcode encoding (matches the CPU ISA)
// and the arbiter state encoding.
package lcd_pkg;

    localparam int OPCODE_W = 3;
    localparam int REG_W    = 4;
    localparam int VALUE_W  = 16;
    localparam int GRANT_W  = 3;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'd0,
        OP_STORE   = 3'd1,
        OP_ADD     = 3'd2,
        OP_SUB     = 3'd3,
        OP_MUL     = 3'd4,
        OP_CLEAR   = 3'd5,
        OP_BLANK   = 3'd6,
        OP_DISPLAY = 3'd7
    } lcd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } arb_state_t;

    // Advance a requester index by one, wrapping to 0 after the last of n requesters.
    function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/lcd_request_arbiter_rr_pick.sv
// Combinational round-robin priority selector: first set request bit at or after rr_ptr,
// scanning upward modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int off = 0; off < N; off++) begin
            pos = (int'(rr_ptr) + off) % N;
            if (!valid && req[pos]) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/lcd_request_arbiter.sv
// Round-robin arbiter sharing one LCD command interface between NUM_REQ requesters;
// each grant issues a one-cycle lcd_start and waits for lcd_busy to clear.
module lcd_request_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MIN_WAIT = 15,
    parameter int TIMEOUT  = 1000000,
    parameter int TMR_W    = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [OPCODE_W*NUM_REQ-1:0]   req_opcode,
    input  logic [REG_W*NUM_REQ-1:0]      req_reg_index,
    input  logic [VALUE_W*NUM_REQ-1:0]    req_value,
    output logic [NUM_REQ-1:0]            done,
    output logic [GRANT_W-1:0]            grant_idx,
    output logic                          active,
    output logic                          timeout_err,
    output logic                          lcd_start,
    output logic [OPCODE_W-1:0]           lcd_opcode,
    output logic [REG_W-1:0]              lcd_reg_index,
    output logic [VALUE_W-1:0]            lcd_value,
    input  logic                          lcd_busy
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TMR_W-1:0] MIN_WAIT_T = TMR_W'(MIN_WAIT);
    localparam logic [TMR_W-1:0] TIMEOUT_T  = TMR_W'(TIMEOUT);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    arb_state_t          state, state_nxt;
    logic [GRANT_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [GRANT_W-1:0]  grant_idx_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic [NUM_REQ-1:0]  done_nxt;
    logic                active_nxt, timeout_err_nxt, lcd_start_nxt;
    logic [OPCODE_W-1:0] lcd_opcode_nxt;
    logic [REG_W-1:0]    lcd_reg_index_nxt;
    logic [VALUE_W-1:0]  lcd_value_nxt;

    logic                pick_valid;
    logic [GRANT_W-1:0]  pick_idx;
    logic [SEL_W-1:0]    pick_sel, grant_sel;
    logic                wait_ok, wait_timeout;

    logic [OPCODE_W-1:0] opcode_arr [NUM_REQ];
    logic [REG_W-1:0]    reg_arr    [NUM_REQ];
    logic [VALUE_W-1:0]  value_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign opcode_arr[g] = req_opcode[g*OPCODE_W +: OPCODE_W];
        assign reg_arr[g]    = req_reg_index[g*REG_W +: REG_W];
        assign value_arr[g]  = req_value[g*VALUE_W +: VALUE_W];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (GRANT_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    assign pick_sel  = pick_idx[SEL_W-1:0];
    assign grant_sel = grant_idx[SEL_W-1:0];

    // Busy is only trusted after MIN_WAIT; a normal completion beats a same-cycle timeout.
    assign wait_ok      = (timer >= MIN_WAIT_T) && !lcd_busy;
    assign wait_timeout = TIMEOUT_EN && (timer == TIMEOUT_T);

    always_comb begin
        state_nxt         = state;
        rr_ptr_nxt        = rr_ptr;
        grant_idx_nxt     = grant_idx;
        timer_nxt         = timer;
        done_nxt          = '0;
        active_nxt        = active;
        timeout_err_nxt   = 1'b0;
        lcd_start_nxt     = 1'b0;
        lcd_opcode_nxt    = lcd_opcode;
        lcd_reg_index_nxt = lcd_reg_index;
        lcd_value_nxt     = lcd_value;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_idx_nxt     = pick_idx;
                    lcd_opcode_nxt    = opcode_arr[pick_sel];
                    lcd_reg_index_nxt = reg_arr[pick_sel];
                    lcd_value_nxt     = value_arr[pick_sel];
                    active_nxt        = 1'b1;
                    lcd_start_nxt     = 1'b1;
                    state_nxt         = ST_START;
                end
            end
            ST_START: begin
                timer_nxt = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Saturate so a disabled timeout cannot wrap the timer back below MIN_WAIT.
                if (timer != '1) begin
                    timer_nxt = timer + 1'b1;
                end
                if (wait_ok) begin
                    done_nxt[grant_sel] = 1'b1;
                    state_nxt           = ST_DONE;
                end else if (wait_timeout) begin
                    done_nxt[grant_sel] = 1'b1;
                    timeout_err_nxt     = 1'b1;
                    state_nxt           = ST_DONE;
                end
            end
            ST_DONE: begin
                active_nxt = 1'b0;
                rr_ptr_nxt = wrap_inc(grant_idx, NUM_REQ);
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            timer         <= '0;
            done          <= '0;
            active        <= 1'b0;
            timeout_err   <= 1'b0;
            lcd_start     <= 1'b0;
            lcd_opcode    <= '0;
            lcd_reg_index <= '0;
            lcd_value     <= '0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            grant_idx     <= grant_idx_nxt;
            timer         <= timer_nxt;
            done          <= done_nxt;
            active        <= active_nxt;
            timeout_err   <= timeout_err_nxt;
            lcd_start     <= lcd_start_nxt;
            lcd_opcode    <= lcd_opcode_nxt;
            lcd_reg_index <= lcd_reg_index_nxt;
            lcd_value     <= lcd_value_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_request_arbiter.sv
// Randomized self-checking bench for lcd_request_arbiter against a transaction-level
// model of round-robin grant order and completion timing.
module tb_lcd_request_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int MIN_WAIT    = 15;
    localparam int TIMEOUT     = 100;
    localparam int TMR_W       = 20;
    localparam int START_BOUND = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_opcode;
    logic [15:0] req_reg_index;
    logic [63:0] req_value;
    logic [3:0]  done;
    logic [2:0]  grant_idx;
    logic        active, timeout_err, lcd_start, lcd_busy;
    logic [2:0]  lcd_opcode;
    logic [3:0]  lcd_reg_index;
    logic [15:0] lcd_value;

    logic [2:0]  op_tab  [4];
    logic [3:0]  reg_tab [4];
    logic [15:0] val_tab [4];

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_opcode[3*g +: 3]     = op_tab[g];
        assign req_reg_index[4*g +: 4]  = reg_tab[g];
        assign req_value[16*g +: 16]    = val_tab[g];
    end

    lcd_request_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MIN_WAIT (MIN_WAIT),
        .TIMEOUT  (TIMEOUT),
        .TMR_W    (TMR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_opcode    (req_opcode),
        .req_reg_index (req_reg_index),
        .req_value     (req_value),
        .done          (done),
        .grant_idx     (grant_idx),
        .active        (active),
        .timeout_err   (timeout_err),
        .lcd_start     (lcd_start),
        .lcd_opcode    (lcd_opcode),
        .lcd_reg_index (lcd_reg_index),
        .lcd_value     (lcd_value),
        .lcd_busy      (lcd_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Round-robin rule: first requesting index at or after ptr, modulo NUM_REQ.
    function automatic int model_pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Cycles (counted from the lcd_start cycle) until done, given busy stays high for
    // cycles 0..busy_hold-1. Completion is decided on the cycle where timer = c-1.
    function automatic int model_done_cyc(input int busy_hold);
        int cn;
        cn = (busy_hold > MIN_WAIT + 1) ? busy_hold : MIN_WAIT + 1;
        if (cn <= TIMEOUT + 1) return cn + 1;
        return TIMEOUT + 2;
    endfunction

    function automatic logic model_terr(input int busy_hold);
        int cn;
        cn = (busy_hold > MIN_WAIT + 1) ? busy_hold : MIN_WAIT + 1;
        return (cn > TIMEOUT + 1);
    endfunction

    task automatic randomize_payloads();
        for (int i = 0; i < NUM_REQ; i++) begin
            op_tab[i]  = 3'($urandom);
            reg_tab[i] = 4'($urandom);
            val_tab[i] = 16'($urandom);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Waits for one grant, drives busy, and records what the DUT did; called at a negedge.
    task automatic run_txn(input int busy_hold, input bit drop_req,
                           output int g_idx, output logic [2:0] g_op, output logic [3:0] g_reg,
                           output logic [15:0] g_val, output int start_cnt, output int done_cyc,
                           output logic [3:0] done_vec, output int done_pulses,
                           output logic terr, output logic act_s, output logic act_a);
        int waited;
        waited = 0;
        g_idx = -1; g_op = '0; g_reg = '0; g_val = '0;
        start_cnt = 0; done_cyc = -1; done_vec = '0; done_pulses = 0;
        terr = 1'b0; act_s = 1'b0; act_a = 1'b1;
        while (lcd_start !== 1'b1 && waited < START_BOUND) begin
            @(negedge clk);
            waited++;
        end
        if (lcd_start !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL start_wait: lcd_start=%b, required 1 within %0d cycles", lcd_start, START_BOUND);
            return;
        end
        g_idx = int'(grant_idx);
        start_cnt = 1;
        act_s = active;
        lcd_busy = (busy_hold > 0);
        randomize_payloads();
        for (int n = 1; n <= TIMEOUT + 10; n++) begin
            @(negedge clk);
            if (lcd_start === 1'b1) start_cnt++;
            if (done !== 4'b0000) begin
                done_pulses++;
                if (done_cyc < 0) begin
                    done_cyc = n;
                    done_vec = done;
                    terr = timeout_err;
                    g_op = lcd_opcode;
                    g_reg = lcd_reg_index;
                    g_val = lcd_value;
                    if (drop_req && g_idx >= 0 && g_idx < NUM_REQ) req[g_idx] = 1'b0;
                end
            end
            if (done_cyc >= 0 && n == done_cyc + 1) begin
                act_a = active;
                break;
            end
            lcd_busy = (n < busy_hold);
        end
        lcd_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        lcd_busy = 1'b0;
        randomize_payloads();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({done, grant_idx, active, timeout_err, lcd_start} !== 10'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got done=%b grant=%0d active=%b terr=%b start=%b, required all 0",
                     done, grant_idx, active, timeout_err, lcd_start);
        end
        n_checks++;
        if ({lcd_opcode, lcd_reg_index, lcd_value} !== 23'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_payload: got op=%0d reg=%0d val=%h, required 0", lcd_opcode, lcd_reg_index, lcd_value);
        end
        rst = 1'b0;
        model_ptr = 0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (lcd_start !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_empty: got start=%b active=%b, required 0 0", lcd_start, active);
        end
    endtask

    task automatic test_single_request();
        int gi, sc, dc, dp;
        logic [2:0] go; logic [3:0] gr, dv; logic [15:0] gv; logic te, as_, aa;
        op_tab[0] = 3'b001; reg_tab[0] = 4'd5; val_tab[0] = 16'hFFF9;
        req = 4'b0001;
        run_txn(40, 1'b1, gi, go, gr, gv, sc, dc, dv, dp, te, as_, aa);
        n_checks++;
        if (gi !== 0 || sc !== 1 || as_ !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got idx=%0d starts=%0d active=%b, required 0 1 1", gi, sc, as_);
        end
        n_checks++;
        if ({go, gr, gv} !== {3'b001, 4'd5, 16'hFFF9}) begin
            n_fail++;
            $display("[TB] FAIL single_payload: got op=%0d reg=%0d val=%h, required 1 5 fff9", go, gr, gv);
        end
        n_checks++;
        if (dc !== model_done_cyc(40) || dv !== 4'b0001 || dp !== 1) begin
            n_fail++;
            $display("[TB] FAIL single_done: got cyc=%0d vec=%b pulses=%0d, required %0d 0001 1", dc, dv, dp, model_done_cyc(40));
        end
        n_checks++;
        if (te !== 1'b0 || aa !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_end: got terr=%b active_after=%b, required 0 0", te, aa);
        end
        model_ptr = 1;
        req = '0;
    endtask

    task automatic test_fairness();
        int gi, sc, dc, dp, exp_idx;
        logic [2:0] go, eo; logic [3:0] gr, er, dv; logic [15:0] gv, ev; logic te, as_, aa;
        pulse_reset();
        randomize_payloads();
        req = 4'b1111;
        for (int t = 0; t < 6; t++) begin
            exp_idx = model_pick(req, model_ptr);
            eo = op_tab[exp_idx]; er = reg_tab[exp_idx]; ev = val_tab[exp_idx];
            run_txn(MIN_WAIT, 1'b0, gi, go, gr, gv, sc, dc, dv, dp, te, as_, aa);
            n_checks++;
            if (gi !== exp_idx) begin
                n_fail++;
                $display("[TB] FAIL fair_grant[%0d]: got %0d, required %0d", t, gi, exp_idx);
            end
            n_checks++;
            if ({go, gr, gv} !== {eo, er, ev}) begin
                n_fail++;
                $display("[TB] FAIL fair_payload[%0d]: got %h/%h/%h, required %h/%h/%h", t, go, gr, gv, eo, er, ev);
            end
            n_checks++;
            if (dv !== (4'b0001 << exp_idx) || dp !== 1 || sc !== 1 || dc !== model_done_cyc(MIN_WAIT)) begin
                n_fail++;
                $display("[TB] FAIL fair_done[%0d]: got vec=%b pulses=%0d starts=%0d cyc=%0d, required %b 1 1 %0d",
                         t, dv, dp, sc, dc, 4'b0001 << exp_idx, model_done_cyc(MIN_WAIT));
            end
            model_ptr = (exp_idx + 1) % NUM_REQ;
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rotation();
        int gi, sc, dc, dp, exp_idx;
        logic [2:0] go; logic [3:0] gr, dv; logic [15:0] gv; logic te, as_, aa;
        pulse_reset();
        req = 4'b0010;
        for (int t = 0; t < 3; t++) begin
            if (t == 1) req = 4'b0011;
            if (t == 2) req = req | 4'b0010;
            exp_idx = model_pick(req, model_ptr);
            run_txn(0, 1'b1, gi, go, gr, gv, sc, dc, dv, dp, te, as_, aa);
            n_checks++;
            if (gi !== exp_idx || dv !== (4'b0001 << exp_idx)) begin
                n_fail++;
                $display("[TB] FAIL rotation[%0d]: got idx=%0d vec=%b, required %0d %b", t, gi, dv, exp_idx, 4'b0001 << exp_idx);
            end
            model_ptr = (exp_idx + 1) % NUM_REQ;
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_busy();
        int gi, sc, dc, dp, exp_idx;
        logic [2:0] go; logic [3:0] gr, dv; logic [15:0] gv; logic te, as_, aa;
        for (int t = 0; t < 2; t++) begin
            req = 4'b0001 << $urandom_range(0, 3);
            exp_idx = model_pick(req, model_ptr);
            run_txn(0, 1'b1, gi, go, gr, gv, sc, dc, dv, dp, te, as_, aa);
            n_checks++;
            if (gi !== exp_idx || dc !== MIN_WAIT + 2 || dp !== 1 || te !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL no_busy[%0d]: got idx=%0d cyc=%0d pulses=%0d terr=%b, required %0d %0d 1 0",
                         t, gi, dc, dp, te, exp_idx, MIN_WAIT + 2);
            end
            model_ptr = (exp_idx + 1) % NUM_REQ;
            req = '0;
        end
    endtask

    task automatic test_timeout();
        int gi, sc, dc, dp, exp_idx, bh;
        logic [2:0] go; logic [3:0] gr, dv; logic [15:0] gv; logic te, as_, aa;
        int holds [3] = '{1000, TIMEOUT + 1, TIMEOUT + 2};
        for (int t = 0; t < 3; t++) begin
            bh = holds[t];
            req = 4'b0001 << $urandom_range(0, 3);
            exp_idx = model_pick(req, model_ptr);
            run_txn(bh, 1'b1, gi, go, gr, gv, sc, dc, dv, dp, te, as_, aa);
            n_checks++;
            if (dc !== model_done_cyc(bh) || te !== model_terr(bh)) begin
                n_fail++;
                $display("[TB] FAIL timeout_done[%0d]: got cyc=%0d terr=%b, required %0d %b",
                         t, dc, te, model_done_cyc(bh), model_terr(bh));
            end
            n_checks++;
            if (gi !== exp_idx || dv !== (4'b0001 << exp_idx) || dp !== 1 || aa !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL timeout_end[%0d]: got idx=%0d vec=%b pulses=%0d active_after=%b, required %0d %b 1 0",
                         t, gi, dv, dp, aa, exp_idx, 4'b0001 << exp_idx);
            end
            model_ptr = (exp_idx + 1) % NUM_REQ;
            req = '0;
        end
    endtask

    task automatic test_random();
        int gi, sc, dc, dp, exp_idx, bh;
        logic [2:0] go, eo; logic [3:0] gr, er, dv; logic [15:0] gv, ev; logic te, as_, aa;
        req = '0;
        for (int t = 0; t < 12; t++) begin
            req = req | 4'($urandom_range(0, 15));
            if (req == 4'b0000) req = 4'b0001 << $urandom_range(0, 3);
            bh = $urandom_range(0, 60);
            exp_idx = model_pick(req, model_ptr);
            eo = op_tab[exp_idx]; er = reg_tab[exp_idx]; ev = val_tab[exp_idx];
            run_txn(bh, 1'b1, gi, go, gr, gv, sc, dc, dv, dp, te, as_, aa);
            n_checks++;
            if (gi !== exp_idx || {go, gr, gv} !== {eo, er, ev}) begin
                n_fail++;
                $display("[TB] FAIL rand_grant[%0d]: got idx=%0d payload=%h/%h/%h, required %0d %h/%h/%h",
                         t, gi, go, gr, gv, exp_idx, eo, er, ev);
            end
            n_checks++;
            if (dc !== model_done_cyc(bh) || dv !== (4'b0001 << exp_idx) || dp !== 1 || te !== 1'b0 || sc !== 1) begin
                n_fail++;
                $display("[TB] FAIL rand_done[%0d]: got cyc=%0d vec=%b pulses=%0d terr=%b starts=%0d, required %0d %b 1 0 1",
                         t, dc, dv, dp, te, sc, model_done_cyc(bh), 4'b0001 << exp_idx);
            end
            model_ptr = (exp_idx + 1) % NUM_REQ;
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_flight();
        int gi, sc, dc, dp, waited, extra_done;
        logic [2:0] go; logic [3:0] gr, dv; logic [15:0] gv; logic te, as_, aa;
        // Abort while lcd_start is high.
        req = 4'b1111;
        waited = 0;
        while (lcd_start !== 1'b1 && waited < START_BOUND) begin
            @(negedge clk);
            waited++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (lcd_start !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_in_start: got start=%b active=%b, required 0 0", lcd_start, active);
        end
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        // Abort while waiting on busy.
        waited = 0;
        while (lcd_start !== 1'b1 && waited < START_BOUND) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (lcd_start !== 1'b1 || grant_idx !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_regrant: got start=%b grant=%0d, required 1 0", lcd_start, grant_idx);
        end
        lcd_busy = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (active !== 1'b0 || lcd_start !== 1'b0 || done !== 4'b0000 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_in_wait: got active=%b start=%b done=%b terr=%b, required 0 0 0000 0",
                     active, lcd_start, done, timeout_err);
        end
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 4'b0000) extra_done++;
        end
        n_checks++;
        if (extra_done !== 0) begin
            n_fail++;
            $display("[TB] FAIL rst_no_done: got %0d done cycles, required 0", extra_done);
        end
        lcd_busy = 1'b0;
        rst = 1'b0;
        model_ptr = 0;
        run_txn(0, 1'b0, gi, go, gr, gv, sc, dc, dv, dp, te, as_, aa);
        n_checks++;
        if (gi !== 0 || dv !== 4'b0001 || dc !== MIN_WAIT + 2) begin
            n_fail++;
            $display("[TB] FAIL rst_after: got idx=%0d vec=%b cyc=%0d, required 0 0001 %0d", gi, dv, dc, MIN_WAIT + 2);
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        lcd_busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            op_tab[i] = '0; reg_tab[i] = '0; val_tab[i] = '0;
        end
        $display("[TB] starting lcd_request_arbiter bench");
        test_reset();
        test_single_request();
        test_fairness();
        test_rotation();
        test_no_busy();
        test_timeout();
        test_random();
        test_reset_mid_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
